// File: rtl/echo_cancel_sequencer_pkg.sv
// Shared definitions for the echo-cancellation sample sequencer.
//   - FSM state encodings and the state_t enum
//   - adapt_mode codes
//   - IEEE-754 double constants used by the adaptation datapath
//   - cnt_width(): bits needed to hold a saturating counter value
package echo_cancel_sequencer_pkg;

  localparam logic [2:0] ST_IDLE_ENC        = 3'd0;
  localparam logic [2:0] ST_CVT_WAIT_ENC    = 3'd1;
  localparam logic [2:0] ST_ADAPT_WAIT_ENC  = 3'd2;
  localparam logic [2:0] ST_CANCEL_WAIT_ENC = 3'd3;
  localparam logic [2:0] ST_OUT_ENC         = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE        = ST_IDLE_ENC,
    ST_CVT_WAIT    = ST_CVT_WAIT_ENC,
    ST_ADAPT_WAIT  = ST_ADAPT_WAIT_ENC,
    ST_CANCEL_WAIT = ST_CANCEL_WAIT_ENC,
    ST_OUT         = ST_OUT_ENC
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_ALWAYS = 2'd1;
  localparam logic [1:0] MODE_FROZEN = 2'd2;  // code 3 behaves the same

  localparam logic [63:0] GAMMA_0P25 = 64'h3FD0_0000_0000_0000;
  localparam logic [63:0] MU_1P0     = 64'h3FF0_0000_0000_0000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/echo_cancel_sequencer_stage_timeout_counter.sv
// Per-stage watchdog shared by all wait states of the sequencer.
//   clk_operation, rst : clock, synchronous active-high reset
//   clear              : reload the timer (stage entry)
//   run                : a stage is waiting for its done pulse
//   expired            : TIMEOUT_CYC cycles spent in the current stage
// Down-counter loaded with TIMEOUT_CYC-1; terminal count is zero.
module stage_timeout_counter #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk_operation,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = TERM_LOAD;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      cnt_q <= TERM_LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/echo_cancel_sequencer.sv
// Per-sample controller for the echo-cancellation datapath. Each sample tick
// walks conversion -> (optional) NLMS adaptation -> cancellation -> output
// conversion using start/done handshakes, with warm-up staging, training
// length control, per-stage timeouts and overrun detection.
//   clk_operation, rst            : clock, synchronous active-high reset
//   enable, sample_tick           : run enable (sampled in IDLE), sample pulse
//   adapt_mode                    : 0 auto, 1 always, 2/3 frozen
//   cvt_/adapt_/cancel_start,done : stage handshakes
//   e_in, y_in                    : adaptation error, canceller output
//   out_start, out_double         : output converter handshake and data
//   en_samp_adapt, en_samp_cancel : warm-up sampling enables
//   training, iteration           : adaptation status
//   busy, overrun_err, timeout_err: status and sticky errors
//
// state          | meaning
// ST_IDLE        | waiting for sample_tick with enable
// ST_CVT_WAIT    | input conversion running, waiting cvt_done
// ST_ADAPT_WAIT  | para_approx running, waiting adapt_done
// ST_CANCEL_WAIT | canceller running, waiting cancel_done
// ST_OUT         | one cycle: out_start, counter updates
module echo_cancel_sequencer #(
  parameter int DATA_W         = 64,
  parameter int ITER_W         = 32,
  parameter int TRAIN_SAMPLES  = 25,
  parameter int WARMUP_SAMPLES = 2,
  parameter int TIMEOUT_CYC    = 4096
) (
  input  logic              clk_operation,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_tick,
  input  logic [1:0]        adapt_mode,
  output logic              cvt_start,
  input  logic              cvt_done,
  output logic              adapt_start,
  input  logic              adapt_done,
  output logic              cancel_start,
  input  logic              cancel_done,
  input  logic [DATA_W-1:0] e_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              out_start,
  output logic [DATA_W-1:0] out_double,
  output logic              en_samp_adapt,
  output logic              en_samp_cancel,
  output logic              training,
  output logic [ITER_W-1:0] iteration,
  output logic              busy,
  output logic              overrun_err,
  output logic              timeout_err
);

  import echo_cancel_sequencer_pkg::*;

  localparam int TC_W = cnt_width(TRAIN_SAMPLES);
  localparam int SC_W = cnt_width(WARMUP_SAMPLES);
  localparam logic [TC_W-1:0] TRAIN_MAX  = TC_W'(TRAIN_SAMPLES);
  localparam logic [SC_W-1:0] WARM_MAX   = SC_W'(WARMUP_SAMPLES);
  localparam logic [SC_W-1:0] WARM_M1    = (WARMUP_SAMPLES > 0) ? SC_W'(WARMUP_SAMPLES - 1) : '0;

  state_t state_q, state_d;

  logic              cvt_start_q, cvt_start_d;
  logic              adapt_start_q, adapt_start_d;
  logic              cancel_start_q, cancel_start_d;
  logic [DATA_W-1:0] out_double_q, out_double_d;
  logic              do_adapt_q, do_adapt_d;
  logic              training_q, training_d;
  logic [ITER_W-1:0] iteration_q, iteration_d;
  logic [TC_W-1:0]   train_cnt_q, train_cnt_d;
  logic [SC_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic tmo_clear, tmo_run, tmo_expired;
  logic adapt_sel;

  // Stage entry (any state change) reloads the watchdog.
  assign tmo_clear = (state_d != state_q);
  assign tmo_run   = (state_q == ST_CVT_WAIT) || (state_q == ST_ADAPT_WAIT) ||
                     (state_q == ST_CANCEL_WAIT);

  stage_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_stage_timeout (
    .clk_operation (clk_operation),
    .rst           (rst),
    .clear         (tmo_clear),
    .run           (tmo_run),
    .expired       (tmo_expired)
  );

  // Warm-up samples always adapt regardless of mode.
  always_comb begin
    adapt_sel = 1'b0;
    case (adapt_mode)
      MODE_ALWAYS: adapt_sel = 1'b1;
      MODE_AUTO:   adapt_sel = (train_cnt_q < TRAIN_MAX);
      default:     adapt_sel = 1'b0;
    endcase
    if (sample_cnt_q < WARM_MAX) begin
      adapt_sel = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    cvt_start_d    = 1'b0;
    adapt_start_d  = 1'b0;
    cancel_start_d = 1'b0;
    out_double_d   = out_double_q;
    do_adapt_d     = do_adapt_q;
    training_d     = training_q;
    iteration_d    = iteration_q;
    train_cnt_d    = train_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    // A tick in any non-IDLE state, OUT included, is dropped and flagged.
    overrun_d      = overrun_q | (sample_tick && (state_q != ST_IDLE));
    timeout_d      = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (sample_tick && enable) begin
          cvt_start_d = 1'b1;
          do_adapt_d  = adapt_sel;
          training_d  = adapt_sel;
          state_d     = ST_CVT_WAIT;
        end
      end
      ST_CVT_WAIT: begin
        if (cvt_done) begin
          if (do_adapt_q) begin
            adapt_start_d = 1'b1;
            state_d       = ST_ADAPT_WAIT;
          end else begin
            cancel_start_d = 1'b1;
            state_d        = ST_CANCEL_WAIT;
          end
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ADAPT_WAIT: begin
        if (adapt_done) begin
          cancel_start_d = 1'b1;
          state_d        = ST_CANCEL_WAIT;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_CANCEL_WAIT: begin
        // Data is captured on the done cycle so it is valid alongside out_start.
        if (cancel_done) begin
          out_double_d = do_adapt_q ? e_in : y_in;
          state_d      = ST_OUT;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (do_adapt_q) begin
          if (iteration_q != '1) begin
            iteration_d = iteration_q + ITER_W'(1);
          end
          if (train_cnt_q < TRAIN_MAX) begin
            train_cnt_d = train_cnt_q + TC_W'(1);
          end
        end
        if (sample_cnt_q < WARM_MAX) begin
          sample_cnt_d = sample_cnt_q + SC_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cvt_start_q    <= 1'b0;
      adapt_start_q  <= 1'b0;
      cancel_start_q <= 1'b0;
      out_double_q   <= '0;
      do_adapt_q     <= 1'b0;
      training_q     <= 1'b0;
      iteration_q    <= '0;
      train_cnt_q    <= '0;
      sample_cnt_q   <= '0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cvt_start_q    <= cvt_start_d;
      adapt_start_q  <= adapt_start_d;
      cancel_start_q <= cancel_start_d;
      out_double_q   <= out_double_d;
      do_adapt_q     <= do_adapt_d;
      training_q     <= training_d;
      iteration_q    <= iteration_d;
      train_cnt_q    <= train_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  assign cvt_start      = cvt_start_q;
  assign adapt_start    = adapt_start_q;
  assign cancel_start   = cancel_start_q;
  assign out_start      = (state_q == ST_OUT);
  assign out_double     = out_double_q;
  assign en_samp_cancel = (sample_cnt_q >= WARM_M1);
  assign en_samp_adapt  = (sample_cnt_q >= WARM_MAX);
  assign training       = training_q;
  assign iteration      = iteration_q;
  assign busy           = (state_q != ST_IDLE);
  assign overrun_err    = overrun_q;
  assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_echo_cancel_sequencer.sv
module tb_echo_cancel_sequencer;

  localparam int DATA_W = 64;
  localparam int ITER_W = 32;

  logic              clk_operation = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              sample_tick = 1'b0;
  logic [1:0]        adapt_mode = 2'd0;
  logic              cvt_done = 1'b0;
  logic              adapt_done = 1'b0;
  logic              cancel_done = 1'b0;
  logic [DATA_W-1:0] e_in = '0;
  logic [DATA_W-1:0] y_in = '0;
  logic              cvt_start, adapt_start, cancel_start, out_start;
  logic [DATA_W-1:0] out_double;
  logic              en_samp_adapt, en_samp_cancel, training, busy;
  logic              overrun_err, timeout_err;
  logic [ITER_W-1:0] iteration;

  echo_cancel_sequencer #(
    .DATA_W         (DATA_W),
    .ITER_W         (ITER_W),
    .TRAIN_SAMPLES  (3),
    .WARMUP_SAMPLES (2),
    .TIMEOUT_CYC    (16)
  ) dut (
    .clk_operation  (clk_operation),
    .rst            (rst),
    .enable         (enable),
    .sample_tick    (sample_tick),
    .adapt_mode     (adapt_mode),
    .cvt_start      (cvt_start),
    .cvt_done       (cvt_done),
    .adapt_start    (adapt_start),
    .adapt_done     (adapt_done),
    .cancel_start   (cancel_start),
    .cancel_done    (cancel_done),
    .e_in           (e_in),
    .y_in           (y_in),
    .out_start      (out_start),
    .out_double     (out_double),
    .en_samp_adapt  (en_samp_adapt),
    .en_samp_cancel (en_samp_cancel),
    .training       (training),
    .iteration      (iteration),
    .busy           (busy),
    .overrun_err    (overrun_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk_operation = ~clk_operation;

  int n_checks = 0;
  int n_errors = 0;
  int n_cvt = 0;
  int n_out = 0;

  typedef struct {
    bit          do_rst;
    logic [1:0]  mode;
    logic [63:0] e;
    logic [63:0] y;
    bit          exp_adapt;
    logic [63:0] exp_out;
    int          exp_iter;
    bit          exp_train;
    bit          exp_enc;
    bit          exp_ena;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk_operation);
    #1;
    if (cvt_start) n_cvt++;
    if (out_start) n_out++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_tick = 1'b0;
    cvt_done = 1'b0;
    adapt_done = 1'b0;
    cancel_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete sample with done pulses 5 cycles after each start.
  task automatic run_vec(input vec_t v, input int idx);
    if (v.do_rst) do_reset();
    adapt_mode = v.mode;
    e_in = v.e;
    y_in = v.y;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk($sformatf("v%0d cvt_start", idx), cvt_start, 1);
    repeat (4) step();
    cvt_done = 1'b1;
    step();
    cvt_done = 1'b0;
    chk($sformatf("v%0d adapt_start", idx), adapt_start, v.exp_adapt);
    if (v.exp_adapt) begin
      chk($sformatf("v%0d no_early_cancel", idx), cancel_start, 0);
      repeat (4) step();
      adapt_done = 1'b1;
      step();
      adapt_done = 1'b0;
    end
    chk($sformatf("v%0d cancel_start", idx), cancel_start, 1);
    repeat (4) step();
    cancel_done = 1'b1;
    step();
    cancel_done = 1'b0;
    chk($sformatf("v%0d out_start", idx), out_start, 1);
    chk($sformatf("v%0d out_double", idx), out_double, v.exp_out);
    chk($sformatf("v%0d training", idx), training, v.exp_train);
    step();
    chk($sformatf("v%0d out_start_end", idx), out_start, 0);
    chk($sformatf("v%0d busy", idx), busy, 0);
    chk($sformatf("v%0d iteration", idx), iteration, 64'(v.exp_iter));
    chk($sformatf("v%0d en_samp_cancel", idx), en_samp_cancel, v.exp_enc);
    chk($sformatf("v%0d en_samp_adapt", idx), en_samp_adapt, v.exp_ena);
    chk($sformatf("v%0d out_double_hold", idx), out_double, v.exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int o0;
    vec_t v;

    // Auto mode, TRAIN_SAMPLES=3: three adapted samples then frozen.
    vecs[0] = '{0, 2'd0, 64'hE1, 64'hA1, 1, 64'hE1, 1, 1, 1, 0};
    vecs[1] = '{0, 2'd0, 64'hE2, 64'hA2, 1, 64'hE2, 2, 1, 1, 1};
    vecs[2] = '{0, 2'd0, 64'hE3, 64'hA3, 1, 64'hE3, 3, 1, 1, 1};
    vecs[3] = '{0, 2'd0, 64'hE4, 64'hA4, 0, 64'hA4, 3, 0, 1, 1};
    // Frozen after reset: two warm-up samples still adapt.
    vecs[4] = '{1, 2'd2, 64'hE5, 64'hA5, 1, 64'hE5, 1, 1, 1, 0};
    vecs[5] = '{0, 2'd2, 64'hE6, 64'hA6, 1, 64'hE6, 2, 1, 1, 1};
    vecs[6] = '{0, 2'd2, 64'hE7, 64'hA7, 0, 64'hA7, 2, 0, 1, 1};
    vecs[7] = '{0, 2'd3, 64'hE8, 64'hA8, 0, 64'hA8, 2, 0, 1, 1};
    vecs[8] = '{0, 2'd1, 64'hE9, 64'hA9, 1, 64'hE9, 3, 1, 1, 1};

    enable = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk("rst cvt_start", cvt_start, 0);
    chk("rst adapt_start", adapt_start, 0);
    chk("rst cancel_start", cancel_start, 0);
    chk("rst out_start", out_start, 0);
    chk("rst out_double", out_double, 0);
    chk("rst en_samp", {en_samp_adapt, en_samp_cancel}, 0);
    chk("rst training", training, 0);
    chk("rst iteration", iteration, 0);
    chk("rst busy", busy, 0);
    chk("rst errors", {overrun_err, timeout_err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Withheld adapt_done: 16 cycles in ADAPT_WAIT, then timeout.
    adapt_mode = 2'd1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    cvt_done = 1'b1;
    step();
    cvt_done = 1'b0;
    chk("tmo adapt_start", adapt_start, 1);
    o0 = n_out;
    repeat (15) step();
    chk("tmo not_yet", timeout_err, 0);
    chk("tmo busy_before", busy, 1);
    step();
    chk("tmo timeout_err", timeout_err, 1);
    chk("tmo busy_after", busy, 0);
    chk("tmo no_out_start", 64'(n_out - o0), 0);
    chk("tmo iteration", iteration, 3);
    v = '{0, 2'd1, 64'hE10, 64'hA10, 1, 64'hE10, 4, 1, 1, 1};
    run_vec(v, 9);
    chk("tmo sticky", timeout_err, 1);

    // Tick during CANCEL_WAIT: flagged and dropped.
    c0 = n_cvt;
    o0 = n_out;
    e_in = 64'hE11;
    y_in = 64'hA11;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    cvt_done = 1'b1;
    step();
    cvt_done = 1'b0;
    adapt_done = 1'b1;
    step();
    adapt_done = 1'b0;
    chk("ovr cancel_start", cancel_start, 1);
    chk("ovr clean_before", overrun_err, 0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("ovr overrun_err", overrun_err, 1);
    cancel_done = 1'b1;
    step();
    cancel_done = 1'b0;
    chk("ovr out_start", out_start, 1);
    chk("ovr out_double", out_double, 64'hE11);
    repeat (3) step();
    chk("ovr single_out", 64'(n_out - o0), 1);
    chk("ovr single_cvt", 64'(n_cvt - c0), 1);
    chk("ovr iteration", iteration, 5);
    chk("ovr busy", busy, 0);

    // Enable low: tick ignored in IDLE; stray done pulses ignored.
    enable = 1'b0;
    sample_tick = 1'b1;
    cancel_done = 1'b1;
    step();
    sample_tick = 1'b0;
    cancel_done = 1'b0;
    chk("dis cvt_start", cvt_start, 0);
    chk("dis busy", busy, 0);
    chk("dis stray_done", out_start, 0);
    enable = 1'b1;

    // Reset during ADAPT_WAIT abandons the sample.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    cvt_done = 1'b1;
    step();
    cvt_done = 1'b0;
    chk("mrst adapt_start", adapt_start, 1);
    chk("mrst overrun_pre", overrun_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst busy", busy, 0);
    chk("mrst starts", {cvt_start, adapt_start, cancel_start, out_start}, 0);
    chk("mrst out_double", out_double, 0);
    chk("mrst iteration", iteration, 0);
    chk("mrst status", {training, en_samp_adapt, en_samp_cancel}, 0);
    chk("mrst errors", {overrun_err, timeout_err}, 0);
    o0 = n_out;
    adapt_done = 1'b1;
    cancel_done = 1'b1;
    step();
    adapt_done = 1'b0;
    cancel_done = 1'b0;
    step();
    chk("mrst no_out_start", 64'(n_out - o0), 0);
    chk("mrst idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/echo_cancel_sequencer.md
Name: echo_cancel_sequencer

Overview:
Synthesizable, parametrised per-sample controller for the echo-cancellation datapath. It replaces delay-timed enables with start/done handshakes across four stages: 16b-to-double conversion, NLMS parameter adaptation, echo cancellation, and double-to-16b output. It adds selectable adaptation modes, a parametrised training length, warm-up staging, per-stage timeouts and overrun detection. It sits between the sample-rate tick generator and the existing converter, para_approx and canceller instances.

Parameters:
DATA_W, 64, width of double-precision data buses
ITER_W, 32, width of the iteration counter
TRAIN_SAMPLES, 25, adapted samples before auto mode freezes parameters
WARMUP_SAMPLES, 2, samples before adaptation sampling is enabled (canceller sampling enables after WARMUP_SAMPLES-1)
TIMEOUT_CYC, 4096, maximum clk_operation cycles to wait for any done

Ports:
clk_operation  in  1  operation clock
rst  in  1  synchronous, active-high reset
enable  in  1  run enable, sampled only in IDLE
sample_tick  in  1  one-cycle pulse per audio sample
adapt_mode  in  2  0 auto (train then freeze), 1 always adapt, 2 frozen, 3 treated as 2
cvt_start  out  1  pulse that starts both input converters
cvt_done  in  1  pulse: both conversions complete
adapt_start  out  1  pulse that starts para_approx
adapt_done  in  1  pulse: adaptation complete
cancel_start  out  1  pulse that starts the canceller
cancel_done  in  1  pulse: cancellation complete
e_in  in  DATA_W  adaptation error
y_in  in  DATA_W  canceller output
out_start  out  1  pulse that starts the output converter
out_double  out  DATA_W  value handed to the output converter
en_samp_adapt  out  1  sampling enable to para_approx
en_samp_cancel  out  1  sampling enable to the canceller
training  out  1  the current or last sample used adaptation
iteration  out  ITER_W  completed adapted samples, saturating
busy  out  1  FSM not in IDLE
overrun_err  out  1  sticky: a tick arrived while busy
timeout_err  out  1  sticky: a stage exceeded TIMEOUT_CYC

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; sample, train and timeout counters clear. Reset mid-sample abandons the sample with no output pulse.
- States: IDLE, CVT_WAIT, ADAPT_WAIT, CANCEL_WAIT, OUT.
- IDLE: on sample_tick with enable=1, assert cvt_start for one cycle (cycle t+1 after tick at t) and go to CVT_WAIT. Latch do_adapt = (mode 1) or (mode 0 and train_cnt < TRAIN_SAMPLES) or sample_cnt < WARMUP_SAMPLES. training <= do_adapt.
- CVT_WAIT: on cvt_done at cycle d, if do_adapt assert adapt_start at d+1 and go to ADAPT_WAIT; otherwise assert cancel_start at d+1 and go to CANCEL_WAIT.
- ADAPT_WAIT: on adapt_done, assert cancel_start the next cycle and go to CANCEL_WAIT.
- CANCEL_WAIT: on cancel_done go to OUT.
- OUT: single cycle. out_start=1; out_double <= e_in if do_adapt, else y_in. If do_adapt, iteration +1 (saturating at all-ones) and train_cnt +1 (saturating at TRAIN_SAMPLES). sample_cnt +1 (saturating at WARMUP_SAMPLES). Return to IDLE.
- out_double holds its value until the next OUT.
- Warm-up: en_samp_cancel = (sample_cnt >= WARMUP_SAMPLES-1); en_samp_adapt = (sample_cnt >= WARMUP_SAMPLES).
- Timeout: the wait counter clears on entry to each WAIT state. On reaching TIMEOUT_CYC-1 with no done: set timeout_err, return to IDLE, no out_start, counters unchanged.
- Stray done pulses in IDLE or a non-matching state are ignored.
- sample_tick while busy: set overrun_err; the tick is dropped and the current sample continues. A tick in the same cycle as OUT is also an overrun.
- enable deasserted mid-sample: the current sample completes, then the FSM stays in IDLE.
- adapt_mode changes take effect at the next sample latch only.
- A sticky error clears only on rst.

Decomposition:
- Shared package: state encoding localparams, adapt_mode codes (MODE_AUTO, MODE_ALWAYS, MODE_FROZEN), IEEE-754 double constants (GAMMA_0P25, MU_1P0).
- One sub-module, stage_timeout_counter: clear and run inputs, expired output, parametrised by TIMEOUT_CYC. Reused across all wait states.

Test Plan:
- Auto mode, TRAIN_SAMPLES=3, done pulses 5 cycles after each start: samples 1-3 issue adapt_start and output e_in; sample 4 skips adapt and outputs y_in. iteration ends at 3.
- Frozen mode after reset, WARMUP_SAMPLES=2: the first 2 samples still adapt. en_samp_cancel rises after sample 1 and en_samp_adapt after sample 2. From sample 3 on, no adapt_start.
- Tick at cycle t: cvt_start at t+1. cvt_done at d gives adapt_start at d+1; cancel_done at c gives out_start at c+1 with the exact out_double value.
- Withhold adapt_done with TIMEOUT_CYC=16: timeout_err=1 after 16 cycles in ADAPT_WAIT, FSM back in IDLE, no out_start, iteration unchanged. The next tick is processed normally.
- Tick during CANCEL_WAIT: overrun_err=1, the current sample completes with a single out_start, and no extra cvt_start is issued.
- Assert rst during ADAPT_WAIT: next cycle all outputs are 0 and busy=0. A later cancel_done produces no out_start.
